// File: rtl/biu_arb2.sv
//==============================================================================
// biu_arb2 : two-master round-robin arbiter with lock hold in front of the BIU
// Rev 1.0
//==============================================================================
`default_nettype none

module biu_arb2 #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = DATA_SIZE
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,

  input  logic                 biu0_stb_i,
  output logic                 biu0_stb_ack_o,
  output logic                 biu0_d_ack_o,
  input  logic [ADDR_SIZE-1:0] biu0_adri_i,
  output logic [ADDR_SIZE-1:0] biu0_adro_o,
  input  logic [2:0]           biu0_size_i,
  input  logic [2:0]           biu0_type_i,
  input  logic [2:0]           biu0_prot_i,
  input  logic                 biu0_lock_i,
  input  logic                 biu0_we_i,
  input  logic [DATA_SIZE-1:0] biu0_d_i,
  output logic [DATA_SIZE-1:0] biu0_q_o,
  output logic                 biu0_ack_o,
  output logic                 biu0_err_o,

  input  logic                 biu1_stb_i,
  output logic                 biu1_stb_ack_o,
  output logic                 biu1_d_ack_o,
  input  logic [ADDR_SIZE-1:0] biu1_adri_i,
  output logic [ADDR_SIZE-1:0] biu1_adro_o,
  input  logic [2:0]           biu1_size_i,
  input  logic [2:0]           biu1_type_i,
  input  logic [2:0]           biu1_prot_i,
  input  logic                 biu1_lock_i,
  input  logic                 biu1_we_i,
  input  logic [DATA_SIZE-1:0] biu1_d_i,
  output logic [DATA_SIZE-1:0] biu1_q_o,
  output logic                 biu1_ack_o,
  output logic                 biu1_err_o,

  output logic                 biu_stb_o,
  input  logic                 biu_stb_ack_i,
  input  logic                 biu_d_ack_i,
  output logic [ADDR_SIZE-1:0] biu_adri_o,
  input  logic [ADDR_SIZE-1:0] biu_adro_i,
  output logic [2:0]           biu_size_o,
  output logic [2:0]           biu_type_o,
  output logic [2:0]           biu_prot_o,
  output logic                 biu_lock_o,
  output logic                 biu_we_o,
  output logic [DATA_SIZE-1:0] biu_d_o,
  input  logic [DATA_SIZE-1:0] biu_q_i,
  input  logic                 biu_ack_i,
  input  logic                 biu_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_q;
  logic        owner_q;
  logic        last_q;
  logic        locked_q;
  logic [3:0]  beat_cnt_q;

  logic        w_own_stb;
  logic        w_own_lock;
  logic [2:0]  w_own_type;
  logic        w_req;
  logic        w_data;

  // Burst types come in pairs {SINGLE,INCR},{WRAP4,INCR4},{WRAP8,INCR8},{WRAP16,INCR16},
  // so the upper two type bits alone select the remaining-beat count.
  function automatic logic [3:0] type2cnt(input logic [1:0] pair);
    case (pair)
      2'd0:    type2cnt = 4'd0;
      2'd1:    type2cnt = 4'd3;
      2'd2:    type2cnt = 4'd7;
      default: type2cnt = 4'd15;
    endcase
  endfunction

  assign w_own_stb  = owner_q ? biu1_stb_i  : biu0_stb_i;
  assign w_own_lock = owner_q ? biu1_lock_i : biu0_lock_i;
  assign w_own_type = owner_q ? biu1_type_i : biu0_type_i;
  assign w_req      = (state_q == ST_REQ);
  assign w_data     = (state_q == ST_DATA);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      locked_q   <= 1'b0;
      beat_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A held lock parks the grant on the current owner until it asks again.
          if (locked_q) begin
            if (w_own_stb) state_q <= ST_REQ;
          end else if (biu0_stb_i ^ biu1_stb_i) begin
            owner_q <= biu1_stb_i;
            state_q <= ST_REQ;
          end else if (biu0_stb_i & biu1_stb_i) begin
            owner_q <= ~last_q;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!w_own_stb) begin
            state_q <= ST_IDLE;
          end else if (biu_stb_ack_i) begin
            beat_cnt_q <= type2cnt(w_own_type[2:1]);
            last_q     <= owner_q;
            locked_q   <= w_own_lock;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (biu_err_i) begin
            beat_cnt_q <= 4'd0;
            locked_q   <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (biu_ack_i) begin
            if (beat_cnt_q == 4'd0) state_q    <= ST_IDLE;
            else                    beat_cnt_q <= beat_cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign biu_stb_o  = w_req & w_own_stb;
  assign biu_adri_o = owner_q ? biu1_adri_i : biu0_adri_i;
  assign biu_size_o = owner_q ? biu1_size_i : biu0_size_i;
  assign biu_type_o = w_own_type;
  assign biu_prot_o = owner_q ? biu1_prot_i : biu0_prot_i;
  assign biu_lock_o = w_own_lock;
  assign biu_we_o   = owner_q ? biu1_we_i   : biu0_we_i;
  assign biu_d_o    = owner_q ? biu1_d_i    : biu0_d_i;

  assign biu0_stb_ack_o = w_req  & ~owner_q & biu_stb_ack_i;
  assign biu1_stb_ack_o = w_req  &  owner_q & biu_stb_ack_i;
  assign biu0_d_ack_o   = w_data & ~owner_q & biu_d_ack_i;
  assign biu1_d_ack_o   = w_data &  owner_q & biu_d_ack_i;
  assign biu0_ack_o     = w_data & ~owner_q & biu_ack_i;
  assign biu1_ack_o     = w_data &  owner_q & biu_ack_i;
  assign biu0_err_o     = w_data & ~owner_q & biu_err_i;
  assign biu1_err_o     = w_data &  owner_q & biu_err_i;

  // Read data and beat address fan out to both masters; ack qualifies them.
  assign biu0_q_o    = biu_q_i;
  assign biu1_q_o    = biu_q_i;
  assign biu0_adro_o = biu_adro_i;
  assign biu1_adro_o = biu_adro_i;

endmodule

`default_nettype wire
